// File: rtl/adv_pkg.sv
// Room codes, display glyph set and the room -> 4-character name table.
// Pure combinational helpers; no state lives here.
package adv_pkg;

    localparam logic [2:0] CC  = 3'b000;
    localparam logic [2:0] TT  = 3'b001;
    localparam logic [2:0] GG  = 3'b011;
    localparam logic [2:0] SSS = 3'b100;
    localparam logic [2:0] RR  = 3'b101;
    localparam logic [2:0] DD  = 3'b110;
    localparam logic [2:0] VV  = 3'b111;

    typedef enum logic [3:0] {
        G_C, G_A, G_U, G_E, G_T, G_N, G_L, G_S,
        G_H, G_R, G_I, G_D, G_G, G_IL, G_BLANK, G_DASH
    } glyph_t;

    // idx 0 is the rightmost character (an[0]), idx 3 the leftmost.
    function automatic glyph_t name_glyph(input logic [2:0] room, input logic [1:0] idx);
        logic [15:0] w_name;
        case (room)
            CC:      w_name = {G_C, G_A, G_U, G_E};
            TT:      w_name = {G_T, G_U, G_N, G_L};
            SSS:     w_name = {G_S, G_T, G_S, G_H};
            RR:      w_name = {G_R, G_I, G_U, G_R};
            DD:      w_name = {G_D, G_R, G_A, G_G};
            GG:      w_name = {G_D, G_E, G_A, G_D};
            VV:      w_name = {G_U, G_I, G_N, G_BLANK};
            default: w_name = {G_DASH, G_DASH, G_DASH, G_DASH};
        endcase
        return glyph_t'(w_name[{idx, 2'b00} +: 4]);
    endfunction

endpackage

// File: rtl/room_display_scanner_glyph_to_seg.sv
// Glyph code to active-low segment pattern {g,f,e,d,c,b,a}.
// Combinational, zero latency.
module glyph_to_seg
    import adv_pkg::*;
(
    input  glyph_t     i_glyph,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'h7F;
        case (i_glyph)
            G_C:     o_seg = 7'h46;
            G_A:     o_seg = 7'h08;
            G_U:     o_seg = 7'h41;
            G_E:     o_seg = 7'h06;
            G_T:     o_seg = 7'h07;
            G_N:     o_seg = 7'h2B;
            G_L:     o_seg = 7'h47;
            G_S:     o_seg = 7'h12;
            G_H:     o_seg = 7'h09;
            G_R:     o_seg = 7'h2F;
            G_I:     o_seg = 7'h79;
            G_D:     o_seg = 7'h21;
            G_G:     o_seg = 7'h42;
            G_IL:    o_seg = 7'h7B;
            G_BLANK: o_seg = 7'h7F;
            G_DASH:  o_seg = 7'h3F;
            default: o_seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/room_display_scanner.sv
// Multiplexed 4-digit 7-seg room-name display with change blanking, end-game blink and sword dp.
// Pins are registered from the next-state digit, so they follow a slot tick by one cycle.
module room_display_scanner
    import adv_pkg::*;
#(
    parameter int SCAN_BITS  = 16,
    parameter int BLINK_BITS = 6
) (
    input  logic       CLK,
    input  logic       Reset_n,
    input  logic [2:0] rooms,
    input  logic       sword,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    logic [SCAN_BITS-1:0]  r_scan_cnt;
    logic [1:0]            r_digit;
    logic [BLINK_BITS-1:0] r_frame_cnt;
    logic [2:0]            r_blank_cnt;
    logic [2:0]            r_prev_room;
    logic                  r_live;
    logic [6:0]            r_seg;
    logic                  r_dp;
    logic [3:0]            r_an;

    logic                  w_tick;
    logic                  w_room_chg;
    logic [1:0]            w_digit_nxt;
    logic [BLINK_BITS-1:0] w_frame_nxt;
    logic [2:0]            w_blank_nxt;
    logic                  w_blink;
    logic                  w_dark;
    glyph_t                w_glyph;
    logic [6:0]            w_seg;

    assign w_tick      = &r_scan_cnt;
    assign w_room_chg  = (rooms != r_prev_room);
    assign w_digit_nxt = w_tick ? r_digit + 2'd1 : r_digit;
    assign w_frame_nxt = (w_tick && r_digit == 2'd3) ? r_frame_cnt + BLINK_BITS'(1) : r_frame_cnt;

    // A room change reloads the blank window even on a slot tick.
    always_comb begin
        w_blank_nxt = r_blank_cnt;
        if (w_room_chg)
            w_blank_nxt = 3'd4;
        else if (w_tick && r_blank_cnt != 3'd0)
            w_blank_nxt = r_blank_cnt - 3'd1;
    end

    assign w_blink = ((rooms == GG) || (rooms == VV)) && w_frame_nxt[BLINK_BITS-1];
    assign w_dark  = (w_blank_nxt != 3'd0) || w_blink;
    assign w_glyph = name_glyph(rooms, w_digit_nxt);

    glyph_to_seg u_glyph_to_seg (
        .i_glyph (w_glyph),
        .o_seg   (w_seg)
    );

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            r_scan_cnt  <= '0;
            r_digit     <= 2'd0;
            r_frame_cnt <= '0;
            r_blank_cnt <= 3'd0;
            r_prev_room <= CC;
            r_live      <= 1'b0;
            r_seg       <= 7'h7F;
            r_dp        <= 1'b1;
            r_an        <= 4'b1111;
        end else begin
            r_scan_cnt  <= r_scan_cnt + SCAN_BITS'(1);
            r_digit     <= w_digit_nxt;
            r_frame_cnt <= w_frame_nxt;
            r_blank_cnt <= w_blank_nxt;
            r_prev_room <= rooms;
            // Pins stay dark after reset until the first slot tick.
            if (r_live || w_tick) begin
                r_live <= 1'b1;
                r_seg  <= w_seg;
                r_dp   <= ~((w_digit_nxt == 2'd0) && sword);
                r_an   <= w_dark ? 4'b1111 : ~(4'b0001 << w_digit_nxt);
            end
        end
    end

    assign seg = r_seg;
    assign dp  = r_dp;
    assign an  = r_an;

endmodule

// File: tb/tb_room_display_scanner.sv
// Directed bench for room_display_scanner with SCAN_BITS=2 (4-cycle slots, 16-cycle frames)
// and BLINK_BITS=2 (2 frames lit, 2 frames dark). cyc counts posedges since reset release.
module tb_room_display_scanner;

    logic       CLK = 1'b0;
    logic       Reset_n = 1'b0;
    logic [2:0] rooms = 3'b000;
    logic       sword = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    localparam logic [6:0] S_C = 7'h46, S_A = 7'h08, S_U = 7'h41, S_E = 7'h06;
    localparam logic [6:0] S_T = 7'h07, S_N = 7'h2B, S_L = 7'h47, S_S = 7'h12;
    localparam logic [6:0] S_H = 7'h09, S_R = 7'h2F, S_D = 7'h21;
    localparam logic [6:0] S_BLANK = 7'h7F, S_DASH = 7'h3F;

    room_display_scanner #(.SCAN_BITS(2), .BLINK_BITS(2)) dut (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .rooms   (rooms),
        .sword   (sword),
        .seg     (seg),
        .dp      (dp),
        .an      (an)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic chk_an(input string tag, input logic [3:0] exp);
        checks++;
        assert (an === exp) else begin
            failures++;
            $error("FAIL %s an observed=%b expected=%b (cyc %0d)", tag, an, exp, cyc);
        end
    endtask

    task automatic chk_seg(input string tag, input logic [6:0] exp);
        checks++;
        assert (seg === exp) else begin
            failures++;
            $error("FAIL %s seg observed=%h expected=%h (cyc %0d)", tag, seg, exp, cyc);
        end
    endtask

    task automatic chk_dp(input string tag, input logic exp);
        checks++;
        assert (dp === exp) else begin
            failures++;
            $error("FAIL %s dp observed=%b expected=%b (cyc %0d)", tag, dp, exp, cyc);
        end
    endtask

    initial begin
        // 1. reset and first slot tick
        repeat (3) @(posedge CLK);
        #1;
        chk_an("rst_an", 4'b1111); chk_seg("rst_seg", 7'h7F); chk_dp("rst_dp", 1'b1);
        Reset_n = 1'b1;
        cyc = 0;
        wait_to(3);  chk_an("pre_tick_dark", 4'b1111); chk_seg("pre_tick_seg", 7'h7F);
        wait_to(4);  chk_an("first_lit_d1", 4'b1101); chk_seg("first_lit_U", S_U); chk_dp("first_dp", 1'b1);
        wait_to(5);  chk_an("hold_d1", 4'b1101);

        // 2. CC scan order
        wait_to(8);  chk_an("cc_d2", 4'b1011); chk_seg("cc_A", S_A);
        wait_to(12); chk_an("cc_d3", 4'b0111); chk_seg("cc_C", S_C);
        wait_to(16); chk_an("cc_d0", 4'b1110); chk_seg("cc_E", S_E);
        wait_to(20); chk_an("cc_wrap_d1", 4'b1101); chk_seg("cc_wrap_U", S_U);

        // 3. room change blanking, reload during blank, reload beating a tick
        wait_to(21); rooms = 3'b001;
        wait_to(22); chk_an("tt_blank_start", 4'b1111);
        wait_to(35); chk_an("tt_blank_end", 4'b1111);
        wait_to(36); chk_an("tt_d1", 4'b1101); chk_seg("tt_n", S_N);
        wait_to(40); chk_an("tt_d2", 4'b1011); chk_seg("tt_U", S_U);
        wait_to(44); chk_an("tt_d3", 4'b0111); chk_seg("tt_t", S_T);
        wait_to(48); chk_an("tt_d0", 4'b1110); chk_seg("tt_L", S_L);
        wait_to(49); rooms = 3'b101;
        wait_to(57); rooms = 3'b110;
        wait_to(64); chk_an("reload_extends", 4'b1111);
        wait_to(71); chk_an("reload_end", 4'b1111);
        wait_to(72); chk_an("dd_d2", 4'b1011); chk_seg("dd_r", S_R);
        wait_to(75); rooms = 3'b001;
        wait_to(88); chk_an("reload_beats_tick", 4'b1111);
        wait_to(91); chk_an("coinc_end", 4'b1111);
        wait_to(92); chk_an("coinc_d3", 4'b0111); chk_seg("coinc_t", S_T);

        // 4. sword decimal point
        wait_to(93); rooms = 3'b100; sword = 1'b1;
        wait_to(108); chk_an("sss_d3", 4'b0111); chk_seg("sss_S3", S_S); chk_dp("sword_d3", 1'b1);
        wait_to(112); chk_an("sss_d0", 4'b1110); chk_seg("sss_H", S_H); chk_dp("sword_d0", 1'b0);
        wait_to(113); chk_dp("sword_d0_hold", 1'b0);
        wait_to(116); chk_seg("sss_S1", S_S); chk_dp("sword_d1", 1'b1);
        wait_to(117); sword = 1'b0;
        wait_to(128); chk_an("nosword_d0", 4'b1110); chk_dp("nosword_dp", 1'b1);

        // 5. end-game blink
        rooms = 3'b111;
        wait_to(144); chk_an("vv_d0", 4'b1110); chk_seg("vv_blank", S_BLANK);
        wait_to(156); chk_an("vv_d3", 4'b0111); chk_seg("vv_U", S_U);
        wait_to(160); chk_an("vv_blink_on", 4'b1111);
        wait_to(164); chk_an("vv_blink_d1", 4'b1111); chk_seg("vv_seg_driven", S_N);
        wait_to(176); chk_an("vv_blink_f2", 4'b1111);
        wait_to(192); chk_an("vv_relit_d0", 4'b1110); chk_seg("vv_relit_seg", S_BLANK);
        wait_to(196); chk_an("vv_relit_d1", 4'b1101); chk_seg("vv_n", S_N);
        wait_to(204); rooms = 3'b011;
        wait_to(220); chk_an("gg_d3", 4'b0111); chk_seg("gg_d", S_D);
        wait_to(224); chk_an("gg_blink_on", 4'b1111);
        wait_to(252); chk_an("gg_blink_f2", 4'b1111);
        wait_to(256); chk_an("gg_relit_d0", 4'b1110); chk_seg("gg_d0", S_D);
        wait_to(260); chk_an("gg_d1", 4'b1101); chk_seg("gg_A", S_A);

        // 6. unused code and mid-frame reset
        rooms = 3'b010;
        wait_to(276); chk_an("dash_d1", 4'b1101); chk_seg("dash_1", S_DASH);
        wait_to(280); chk_an("dash_d2", 4'b1011); chk_seg("dash_2", S_DASH);
        Reset_n = 1'b0;
        step();
        chk_an("midrst_an", 4'b1111); chk_seg("midrst_seg", 7'h7F); chk_dp("midrst_dp", 1'b1);
        Reset_n = 1'b1;
        cyc = 0;
        wait_to(4);  chk_an("post_rst_blank", 4'b1111);
        wait_to(15); chk_an("post_rst_blank_end", 4'b1111);
        wait_to(16); chk_an("post_rst_d0", 4'b1110); chk_seg("post_rst_dash", S_DASH); chk_dp("post_rst_dp", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
